// File: rtl/hex_digit_scanner.sv
// Multiplexed hex display scan controller; build with LEADING_ZERO_BLANK_EN to blank leading zero digits.
// Latency: a load is shown from the first digit-0 SHOW cycle after the next frame boundary.
// Backpressure: loadReady drops while a value waits in the shadow register.
module hex_digit_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 2,
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] dataIn,
  input  logic                    loadValid,
  output logic                    loadReady,
  output logic [3:0]              hexNumber,
  output logic [NUM_DIGITS-1:0]   digitEnableActiveLow,
  output logic [IDX_W-1:0]        digitIndex,
  output logic                    frameStart
);

  localparam int CNT_MAX    = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CNT_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int BLANK_LAST = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;

  typedef enum logic {SHOW, BLANK} state_t;

  state_t                  state, stateNxt;
  logic [4*NUM_DIGITS-1:0] displayReg, displayNxt;
  logic [4*NUM_DIGITS-1:0] shadowReg, shadowNxt;
  logic                    pending, pendingNxt;
  logic [IDX_W-1:0]        idxNxt;
  logic [CNT_W-1:0]        cycleCount, cntNxt;
  logic                    frameStartNxt;
  logic                    advance, wrap, load;
  logic [NUM_DIGITS-1:0]   suppress;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= SHOW;
      displayReg <= '0;
      shadowReg  <= '0;
      pending    <= 1'b0;
      digitIndex <= '0;
      cycleCount <= '0;
      frameStart <= 1'b1;
    end else begin
      state      <= stateNxt;
      displayReg <= displayNxt;
      shadowReg  <= shadowNxt;
      pending    <= pendingNxt;
      digitIndex <= idxNxt;
      cycleCount <= cntNxt;
      frameStart <= frameStartNxt;
    end
  end

  always_comb begin
    stateNxt   = state;
    cntNxt     = cycleCount + CNT_W'(1);
    idxNxt     = digitIndex;
    displayNxt = displayReg;
    shadowNxt  = shadowReg;
    pendingNxt = pending;
    advance    = 1'b0;

    if (state == SHOW) begin
      if (cycleCount == CNT_W'(REFRESH_DIV - 1)) begin
        if (BLANK_CYCLES > 0) begin
          stateNxt = BLANK;
          cntNxt   = '0;
        end else begin
          advance = 1'b1;
        end
      end
    end else if (cycleCount == CNT_W'(BLANK_LAST)) begin
      advance = 1'b1;
    end

    wrap = advance && (digitIndex == IDX_W'(NUM_DIGITS - 1));
    if (advance) begin
      stateNxt = SHOW;
      cntNxt   = '0;
      idxNxt   = wrap ? '0 : digitIndex + IDX_W'(1);
    end

    // Load and transfer are mutually exclusive: one needs pending low, the other high.
    load = loadValid && !pending;
    if (wrap && pending) begin
      displayNxt = shadowReg;
      pendingNxt = 1'b0;
    end
    if (load) begin
      shadowNxt  = dataIn;
      pendingNxt = 1'b1;
    end

    frameStartNxt = (stateNxt == SHOW) && (idxNxt == '0) && (cntNxt == '0);
  end

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is suppressed when it and every more-significant nibble are zero.
  always_comb begin
    logic allZero;
    allZero  = 1'b1;
    suppress = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      allZero     = allZero && (displayReg[4*i +: 4] == 4'h0);
      suppress[i] = allZero;
    end
  end
`else
  assign suppress = '0;
`endif

  assign loadReady = !pending;

  always_comb begin
    hexNumber            = displayReg[3:0];
    digitEnableActiveLow = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digitIndex == IDX_W'(i)) begin
        hexNumber = displayReg[4*i +: 4];
        if (state == SHOW && !suppress[i]) digitEnableActiveLow[i] = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hex_digit_scanner.sv
// Scoreboard bench for hex_digit_scanner: a 4-digit and a 1-digit instance share stimulus.
module tb_hex_digit_scanner;

  localparam int N0 = 4, RD0 = 4, BL0 = 1;
  localparam int N1 = 1, RD1 = 4, BL1 = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        loadValid = 1'b0;
  logic [15:0] dataIn = 16'h0;

  logic       loadReady0, fs0, loadReady1, fs1;
  logic [3:0] hex0, en0, hex1;
  logic [1:0] idx0;
  logic [0:0] en1, idx1;

  hex_digit_scanner #(.NUM_DIGITS(N0), .REFRESH_DIV(RD0), .BLANK_CYCLES(BL0)) dut0 (
    .clk(clk), .reset(reset), .dataIn(dataIn), .loadValid(loadValid),
    .loadReady(loadReady0), .hexNumber(hex0), .digitEnableActiveLow(en0),
    .digitIndex(idx0), .frameStart(fs0)
  );

  hex_digit_scanner #(.NUM_DIGITS(N1), .REFRESH_DIV(RD1), .BLANK_CYCLES(BL1)) dut1 (
    .clk(clk), .reset(reset), .dataIn(dataIn[3:0]), .loadValid(loadValid),
    .loadReady(loadReady1), .hexNumber(hex1), .digitEnableActiveLow(en1),
    .digitIndex(idx1), .frameStart(fs1)
  );

  typedef struct packed {
    logic [3:0] hex;
    logic [3:0] en;
    logic [1:0] idx;
    logic       rdy;
    logic       fs;
  } exp_t;

  exp_t q0[$], q1[$];
  int checks = 0, errors = 0;

  int          mT[2];
  logic [15:0] mD[2], mS[2];
  logic        mP[2];
  bit          mValid = 1'b0;

  // Outputs follow from time since reset and the displayed value alone.
  function automatic exp_t expectOut(int n, int rd, int bl, int t, logic [15:0] d, logic p);
    exp_t e;
    int per, pos, dig, inD;
    per = rd + bl;
    pos = t % (n * per);
    dig = pos / per;
    inD = pos % per;
    e.hex = 4'((d >> (4 * dig)) & 16'hF);
    e.en  = 4'hF;
    if (inD < rd) begin
      e.en[dig] = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      if (dig > 0 && (d >> (4 * dig)) == 16'h0) e.en[dig] = 1'b1;
`endif
    end
    e.idx = 2'(dig);
    e.rdy = !p;
    e.fs  = (pos == 0);
    return e;
  endfunction

  task automatic modelUpdate(int i, int n, int rd, int bl, logic r, logic lv, logic [15:0] data);
    if (r) begin
      mT[i] = 0; mD[i] = 16'h0; mS[i] = 16'h0; mP[i] = 1'b0;
    end else begin
      if ((mT[i] % (n * (rd + bl))) == n * (rd + bl) - 1 && mP[i]) begin
        mD[i] = mS[i];
        mP[i] = 1'b0;
      end else if (lv && !mP[i]) begin
        mS[i] = data;
        mP[i] = 1'b1;
      end
      mT[i]++;
    end
  endtask

  task automatic step(logic r, logic lv, logic [15:0] d);
    @(posedge clk);
    #1;
    if (mValid) begin
      q0.push_back(expectOut(N0, RD0, BL0, mT[0], mD[0], mP[0]));
      q1.push_back(expectOut(N1, RD1, BL1, mT[1], mD[1], mP[1]));
    end
    reset = r;
    loadValid = lv;
    dataIn = d;
    modelUpdate(0, N0, RD0, BL0, r, lv, d);
    modelUpdate(1, N1, RD1, BL1, r, lv, d & 16'h000F);
    if (r) mValid = 1'b1;
  endtask

  task automatic check(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      check("d4.hexNumber", {28'h0, hex0}, {28'h0, e.hex});
      check("d4.enable", {28'h0, en0}, {28'h0, e.en});
      check("d4.digitIndex", {30'h0, idx0}, {30'h0, e.idx});
      check("d4.loadReady", {31'h0, loadReady0}, {31'h0, e.rdy});
      check("d4.frameStart", {31'h0, fs0}, {31'h0, e.fs});
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      check("d1.hexNumber", {28'h0, hex1}, {28'h0, e.hex});
      check("d1.enable", {28'h0, 3'b111, en1}, {28'h0, e.en});
      check("d1.digitIndex", {30'h0, 1'b0, idx1}, {30'h0, e.idx});
      check("d1.loadReady", {31'h0, loadReady1}, {31'h0, e.rdy});
      check("d1.frameStart", {31'h0, fs1}, {31'h0, e.fs});
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] masks [5];
    masks = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F, 16'h0000};

    repeat (3) step(1'b1, 1'b0, 16'h0);
    repeat (7) step(1'b0, 1'b0, 16'h0);

    // Mid-frame load, then a second value held until the shadow frees up.
    step(1'b0, 1'b1, 16'h1A3F);
    for (int k = 0; k < 100 && mP[0]; k++) step(1'b0, 1'b1, 16'hBEEF);
    step(1'b0, 1'b1, 16'hBEEF);
    repeat (50) step(1'b0, 1'b0, 16'h0);

    // Load landing exactly in the boundary cycle with nothing pending.
    for (int k = 0; k < 200 && !(!mP[0] && (mT[0] % 20) == 19); k++) step(1'b0, 1'b0, 16'h0);
    if (mP[0] || (mT[0] % 20) != 19) begin
      errors++;
      $display("FAIL boundaryAlign: could not reach boundary cycle, t=%0d", mT[0]);
    end
    step(1'b0, 1'b1, 16'h5A5A);
    repeat (45) step(1'b0, 1'b0, 16'h0);

    // Reset in the middle of operation with a non-zero display.
    repeat (6) step(1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b0, 16'h0);
    repeat (10) step(1'b0, 1'b0, 16'h0);

    // Leading-zero patterns.
    step(1'b0, 1'b1, 16'h0050);
    repeat (45) step(1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b1, 16'h0000);
    repeat (45) step(1'b0, 1'b0, 16'h0);

    for (int k = 0; k < 1500; k++) begin
      step(($urandom_range(0, 399) == 0),
           ($urandom_range(0, 9) == 0),
           16'($urandom) & masks[$urandom_range(0, 4)]);
    end
    repeat (5) step(1'b0, 1'b0, 16'h0);

    @(negedge clk);
    #1;
    check("q0.drained", q0.size(), 0);
    check("q1.drained", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
